// File: rtl/ctrl_sequencer.sv
// ---------------------------------------------------------------------------
// ctrl_sequencer
//
// Multi-cycle control unit for the 16-bit RISC core. Every instruction walks
// FETCH -> DECODE -> REGREAD -> ALU -> [MEM] -> [REGWR] -> PCUPD, and each
// cycle raises at most one stage enable. The ALU branch flag is captured when
// the ALU cycle closes and later steers the PC update for jump opcodes.
//
// Ports
//   clk_i          core clock; the FSM advances on posedge
//   rst_n_i        asynchronous active-low reset
//   aluop_i[4:0]   decoded op; opcode is aluop_i[4:1]; valid from REGREAD on
//   jmpbranch_i    ALU branch-taken flag, sampled at the end of the ALU cycle
//   mem_ready_i    memory handshake ready, used in FETCH and MEM
//   halt_i         halt request, sampled in PCUPD and while halted
//   en_fetch_o     fetch enable / instruction memory request (held until ready)
//   en_decode_o    decoder latch enable
//   en_regread_o   register file read enable
//   en_alu_o       ALU enable
//   en_mem_o       data memory request (held until ready)
//   mem_we_o       store qualifier, only meaningful while en_mem_o=1
//   en_regwr_o     register file write enable
//   pc_op_o[1:0]   00 NOP, 01 INC, 10 ASSIGN, 11 RESET
//   halted_o       high while halted
//   retired_o[15:0], stalls_o[15:0]
//                  performance counters, present only when the macro
//                  CTRL_PERF_CNT_EN is defined
//
// Build option: CTRL_PERF_CNT_EN adds the retired-instruction and
// memory-stall counters. Without it the control behaviour is identical.
// ---------------------------------------------------------------------------
module ctrl_sequencer #(
    parameter logic [3:0] OP_LDM = 4'd14,
    parameter logic [3:0] OP_STM = 4'd15
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [4:0]  aluop_i,
    input  logic        jmpbranch_i,
    input  logic        mem_ready_i,
    input  logic        halt_i,
    output logic        en_fetch_o,
    output logic        en_decode_o,
    output logic        en_regread_o,
    output logic        en_alu_o,
    output logic        en_mem_o,
    output logic        mem_we_o,
    output logic        en_regwr_o,
    output logic [1:0]  pc_op_o,
    output logic        halted_o
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [15:0] retired_o,
    output logic [15:0] stalls_o
`endif
);

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_REGREAD = 4'd3,
        S_ALU     = 4'd4,
        S_MEM     = 4'd5,
        S_REGWR   = 4'd6,
        S_PCUPD   = 4'd7,
        S_HALT    = 4'd8
    } state_t;

    localparam logic [3:0] OP_JMPA = 4'd12;
    localparam logic [3:0] OP_JMPR = 4'd13;

    localparam logic [1:0] PC_NOP    = 2'b00;
    localparam logic [1:0] PC_INC    = 2'b01;
    localparam logic [1:0] PC_ASSIGN = 2'b10;
    localparam logic [1:0] PC_RESET  = 2'b11;

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;     // opcode captured at the end of the ALU cycle
    logic       br_q, br_d;     // branch flag captured at the end of the ALU cycle

    // The lsb of the decoded op only selects ALU sub-functions.
    logic unused_aluop_lsb;
    assign unused_aluop_lsb = aluop_i[0];

    logic [3:0] opcode;
    assign opcode = aluop_i[4:1];

    // -----------------------------------------------------------------------
    // Opcode classes
    // -----------------------------------------------------------------------
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDM) || (op == OP_STM);
    endfunction

    function automatic logic is_jump_op(input logic [3:0] op);
        return (op == OP_JMPA) || (op == OP_JMPR);
    endfunction

    // Plain ALU ops 0..5 and 8..11 write a result back; 6/7 are reserved
    // and behave as NOPs.
    function automatic logic is_alu_wb_op(input logic [3:0] op);
        return (op <= 4'd5) || ((op >= 4'd8) && (op <= 4'd11));
    endfunction

    // -----------------------------------------------------------------------
    // State and captured-operand registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_RESET;
            op_q    <= 4'd0;
            br_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            br_q    <= br_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        br_d    = br_q;

        case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                if (mem_ready_i) begin
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                state_d = S_REGREAD;
            end

            S_REGREAD: begin
                state_d = S_ALU;
            end

            S_ALU: begin
                // The ALU raises its flag after the mid-cycle negedge, so the
                // closing posedge is the first safe point to capture it.
                op_d = opcode;
                br_d = jmpbranch_i;
                if (is_mem_op(opcode)) begin
                    state_d = S_MEM;
                end else if (is_alu_wb_op(opcode)) begin
                    state_d = S_REGWR;
                end else begin
                    state_d = S_PCUPD;
                end
            end

            S_MEM: begin
                if (mem_ready_i) begin
                    state_d = (op_q == OP_LDM) ? S_REGWR : S_PCUPD;
                end
            end

            S_REGWR: begin
                state_d = S_PCUPD;
            end

            S_PCUPD: begin
                state_d = halt_i ? S_HALT : S_FETCH;
            end

            S_HALT: begin
                if (!halt_i) begin
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_RESET;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Moore output decode
    // -----------------------------------------------------------------------
    always_comb begin
        en_fetch_o   = 1'b0;
        en_decode_o  = 1'b0;
        en_regread_o = 1'b0;
        en_alu_o     = 1'b0;
        en_mem_o     = 1'b0;
        mem_we_o     = 1'b0;
        en_regwr_o   = 1'b0;
        pc_op_o      = PC_NOP;
        halted_o     = 1'b0;

        case (state_q)
            S_RESET: begin
                // While reset is asserted the state already sits in RESET;
                // the PC reset command is only issued once reset releases so
                // the outputs read all-zero during the reset pulse itself.
                pc_op_o = rst_n_i ? PC_RESET : PC_NOP;
            end
            S_FETCH: begin
                en_fetch_o = 1'b1;
            end
            S_DECODE: begin
                en_decode_o = 1'b1;
            end
            S_REGREAD: begin
                en_regread_o = 1'b1;
            end
            S_ALU: begin
                en_alu_o = 1'b1;
            end
            S_MEM: begin
                en_mem_o = 1'b1;
                mem_we_o = (op_q == OP_STM);
            end
            S_REGWR: begin
                en_regwr_o = 1'b1;
            end
            S_PCUPD: begin
                // The branch flag only matters for jumps; every other opcode
                // simply advances the PC.
                pc_op_o = (is_jump_op(op_q) && br_q) ? PC_ASSIGN : PC_INC;
            end
            S_HALT: begin
                halted_o = 1'b1;
            end
            default: begin
                pc_op_o = PC_NOP;
            end
        endcase
    end

`ifdef CTRL_PERF_CNT_EN
    // -----------------------------------------------------------------------
    // Performance counters (free-running, wrap at 0xFFFF)
    // -----------------------------------------------------------------------
    logic [15:0] retired_q, retired_d;
    logic [15:0] stalls_q, stalls_d;

    always_comb begin
        retired_d = retired_q;
        stalls_d  = stalls_q;
        if (state_q == S_PCUPD) begin
            retired_d = retired_q + 16'd1;
        end
        if (((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready_i) begin
            stalls_d = stalls_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            retired_q <= 16'd0;
            stalls_q  <= 16'd0;
        end else begin
            retired_q <= retired_d;
            stalls_q  <= stalls_d;
        end
    end

    assign retired_o = retired_q;
    assign stalls_o  = stalls_q;
`endif

endmodule
